// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the M-extension execute unit: funct3 op codes, unit category, FSM states.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } op_t;

  // Decode steers an instruction to one execute resource by category.
  typedef enum logic [1:0] {
    CatagoryAlu    = 2'd0,
    CatagoryMulDiv = 2'd1,
    CatagoryLsu    = 2'd2,
    CatagoryBranch = 2'd3
  } category_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StMul     = 3'd1,
    StDivPrep = 3'd2,
    StDivIter = 3'd3,
    StDivFix  = 3'd4,
    StDone    = 3'd5
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider on unsigned operands; one quotient bit per cycle, XLEN cycles after start.
// done is high during the cycle whose closing edge produces the final quotient/remainder.
module ex_div_iter
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CntW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [CntW-1:0] cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // shifted < 2*dvs, so diff[XLEN] is set exactly when the trial subtraction underflows.
  assign shifted   = {rem, quo[XLEN-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign done      = (cnt == CntW'(1));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= CntW'(XLEN);
    end else if (cnt != '0) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multi-cycle execute unit: pipelined multiplier, iterative divider, one op in flight.
// Holds the pipeline via stall_o until a one-cycle result strobe; flush aborts anything not yet in DONE.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_write_o,
  output logic [XLEN-1:0]       rd_data_o
);

  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state;
  op_t                   op_q;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0]            mul_cnt;
  logic                  q_neg;
  logic                  r_neg;

  assign ready_o = (state == StIdle);
  assign stall_o = ((state == StIdle) && valid_i && !flush) ||
                   ((state != StIdle) && (state != StDone));

  // Operands are sign-extended to 2*XLEN, so the low 2*XLEN product bits are exact for every signedness.
  logic                  a_sgn;
  logic                  b_sgn;
  logic [2*XLEN-1:0]     mul_a;
  logic [2*XLEN-1:0]     mul_b;
  logic [2*XLEN-1:0]     mul_full;
  logic [2*XLEN-1:0]     mul_out;
  logic [XLEN-1:0]       mul_sel;

  assign a_sgn    = ((op_q == OpMulh) || (op_q == OpMulhsu)) && a_q[XLEN-1];
  assign b_sgn    = (op_q == OpMulh) && b_q[XLEN-1];
  assign mul_a    = {{XLEN{a_sgn}}, a_q};
  assign mul_b    = {{XLEN{b_sgn}}, b_q};
  assign mul_full = mul_a * mul_b;
  assign mul_sel  = (op_q == OpMul) ? mul_out[XLEN-1:0] : mul_out[2*XLEN-1:XLEN];

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_out = mul_full;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_full;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_out = pipe[MUL_STAGES-2];
    end
  endgenerate

  logic            div_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic            div_start;
  logic            div_done;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign div_signed = (op_q == OpDiv) || (op_q == OpRem);
  assign is_rem     = op_q[1];
  assign a_neg      = div_signed && a_q[XLEN-1];
  assign b_neg      = div_signed && b_q[XLEN-1];
  assign a_abs      = a_neg ? -a_q : a_q;
  assign b_abs      = b_neg ? -b_q : b_q;
  assign div_zero   = (b_q == '0);
  assign div_ovf    = div_signed && (a_q == MostNeg) && (b_q == '1);
  assign div_start  = (state == StDivPrep) && !flush && !div_zero && !div_ovf;
  assign quo_fix    = q_neg ? -quo : quo;
  assign rem_fix    = r_neg ? -rem : rem;

  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .start     (div_start),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // Result selection for the edge that enters DONE.
  logic            fin_go;
  logic [XLEN-1:0] fin_data;

  always_comb begin
    fin_go   = 1'b0;
    fin_data = '0;
    case (state)
      StMul: begin
        fin_go   = (mul_cnt == 2'(MUL_STAGES - 1));
        fin_data = mul_sel;
      end
      StDivPrep: begin
        if (div_zero) begin
          fin_go   = 1'b1;
          fin_data = is_rem ? a_q : '1;
        end else if (div_ovf) begin
          fin_go   = 1'b1;
          fin_data = is_rem ? '0 : a_q;
        end
      end
      StDivFix: begin
        fin_go   = 1'b1;
        fin_data = is_rem ? rem_fix : quo_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      op_q       <= OpMul;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      mul_cnt    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      valid_o    <= 1'b0;
      rd_write_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else begin
      valid_o    <= 1'b0;
      rd_write_o <= 1'b0;
      case (state)
        StIdle: begin
          if (valid_i && !flush) begin
            op_q    <= op_t'(op_i);
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            rd_q    <= rd_addr_i;
            mul_cnt <= '0;
            state   <= is_mul_op(op_i) ? StMul : StDivPrep;
          end
        end
        // The strobe is already committed here, so flush has no effect.
        StDone: state <= StIdle;
        default: begin
          if (flush) begin
            state <= StIdle;
          end else if (fin_go) begin
            state      <= StDone;
            valid_o    <= 1'b1;
            rd_write_o <= 1'b1;
            rd_addr_o  <= rd_q;
            rd_data_o  <= fin_data;
          end else begin
            if (state == StMul) mul_cnt <= mul_cnt + 2'd1;
            if (state == StDivPrep) begin
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              state <= StDivIter;
            end
            if ((state == StDivIter) && div_done) state <= StDivFix;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases plus random ops against a wide-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_stall, a_vld, a_wr;
  logic [2:0]  a_op;
  logic [31:0] a_rs1, a_rs2, a_data;
  logic [4:0]  a_rd, a_rdo;

  logic        b_valid, b_ready, b_stall, b_vld, b_wr;
  logic [2:0]  b_op;
  logic [63:0] b_rs1, b_rs2, b_data;
  logic [4:0]  b_rd, b_rdo;

  ex_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .REG_ADDR_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_i(a_valid), .op_i(a_op),
    .rs1_data(a_rs1), .rs2_data(a_rs2), .rd_addr_i(a_rd), .ready_o(a_ready),
    .stall_o(a_stall), .valid_o(a_vld), .rd_addr_o(a_rdo), .rd_write_o(a_wr),
    .rd_data_o(a_data)
  );

  ex_muldiv_unit #(.XLEN(64), .MUL_STAGES(4), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_i(b_valid), .op_i(b_op),
    .rs1_data(b_rs1), .rs2_data(b_rs2), .rd_addr_i(b_rd), .ready_o(b_ready),
    .stall_o(b_stall), .valid_o(b_vld), .rd_addr_o(b_rdo), .rd_write_o(b_wr),
    .rd_data_o(b_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference: exact 128-bit products and language-level signed division.
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] x, input logic [63:0] y);
    logic [63:0]         m;
    logic [127:0]        ux, uy, sx, sy, p;
    logic signed [127:0] ssx, ssy;
    m  = wmask(w);
    ux = {64'b0, x & m};
    uy = {64'b0, y & m};
    sx = x[w-1] ? (ux | {64'hFFFF_FFFF_FFFF_FFFF, ~m}) : ux;
    sy = y[w-1] ? (uy | {64'hFFFF_FFFF_FFFF_FFFF, ~m}) : uy;
    ssx = sx;
    ssy = sy;
    p = '0;
    case (op)
      3'd0: p = ux * uy;
      3'd1: p = ssx * ssy;
      3'd2: p = sx * uy;
      3'd3: p = ux * uy;
      3'd4: if (uy == 0) p = '1; else p = ssx / ssy;
      3'd5: if (uy == 0) p = '1; else p = ux / uy;
      3'd6: if (uy == 0) p = ux; else p = ssx % ssy;
      default: if (uy == 0) p = ux; else p = ux % uy;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) p = p >> w;
    return p[63:0] & m;
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] op,
                                 input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    m = wmask(w);
    if (op < 3'd4) return (w == 32) ? 2 : 4;
    if ((y & m) == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && ((x & m) == (64'd1 << (w - 1))) && ((y & m) == m)) return 1;
    return w + 2;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = wmask(w);
      2: v = 64'd1 << (w - 1);
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom} & wmask(w);
    endcase
    return v;
  endfunction

  task automatic drive(input int w, input logic v, input logic [2:0] op,
                       input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd);
    if (w == 32) begin
      a_valid = v; a_op = op; a_rs1 = x[31:0]; a_rs2 = y[31:0]; a_rd = rd;
    end else begin
      b_valid = v; b_op = op; b_rs1 = x; b_rs2 = y; b_rd = rd;
    end
  endtask

  task automatic peek(input int w, output logic vld, output logic stall, output logic rdy,
                      output logic wr, output logic [4:0] rdo, output logic [63:0] d);
    if (w == 32) begin
      vld = a_vld; stall = a_stall; rdy = a_ready; wr = a_wr; rdo = a_rdo; d = {32'b0, a_data};
    end else begin
      vld = b_vld; stall = b_stall; rdy = b_ready; wr = b_wr; rdo = b_rdo; d = b_data;
    end
  endtask

  task automatic run_op(input string tag, input int w, input logic [2:0] op,
                        input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd,
                        input int exp_lat, input logic [63:0] exp_data);
    logic vld, stall, rdy, wr;
    logic [4:0] rdo;
    logic [63:0] d;
    int lat;
    logic stall_ok;
    @(negedge clk);
    drive(w, 1'b1, op, x, y, rd);
    #1 peek(w, vld, stall, rdy, wr, rdo, d);
    stall_ok = rdy && stall;
    @(posedge clk);
    #1 drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      peek(w, vld, stall, rdy, wr, rdo, d);
      if (vld) begin
        lat = c;
        break;
      end
      if (!stall || rdy) stall_ok = 1'b0;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".data"}, d, exp_data);
    chk({tag, ".addr_wr_stall"}, {57'b0, rdo, wr, stall}, {57'b0, rd, 1'b1, 1'b0});
    chk({tag, ".busy_stall"}, 64'(stall_ok), 64'd1);
    @(negedge clk);
    peek(w, vld, stall, rdy, wr, rdo, d);
    chk({tag, ".after"}, {62'b0, vld, rdy}, 64'b01);
  endtask

  task automatic run_ref(input string tag, input int w, input logic [2:0] op,
                         input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd);
    run_op(tag, w, op, x, y, rd, ref_lat(w, op, x, y), ref_model(w, op, x, y));
  endtask

  initial begin
    logic vld, stall, rdy, wr, seen;
    logic [4:0] rdo;
    logic [63:0] d, x, y;
    logic [2:0] op;

    drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    drive(64, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    repeat (3) @(negedge clk);
    peek(32, vld, stall, rdy, wr, rdo, d);
    chk("reset32", {d[31:0], 27'b0, rdo, vld, wr, rdy}, {32'b0, 27'b0, 5'd0, 1'b0, 1'b0, 1'b1});
    peek(64, vld, stall, rdy, wr, rdo, d);
    chk("reset64.data", d, 64'd0);
    chk("reset64.ctl", {56'b0, rdo, vld, wr, rdy}, {56'b0, 5'd0, 3'b001});
    rst_n = 1'b1;

    run_op("mul", 32, 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd5, 2, 64'hFFFF_FFEB);
    run_op("mulh", 32, 3'd1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd1, 2, 64'h0000_0000);
    run_op("mulhsu", 32, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF, 5'd2, 2, 64'h8000_0000);
    run_op("mulhu", 32, 3'd3, 64'h8000_0000, 64'hFFFF_FFFF, 5'd3, 2, 64'h7FFF_FFFF);
    run_op("div", 32, 3'd4, 64'hFFFF_FFEC, 64'd3, 5'd6, 34, 64'hFFFF_FFFA);
    run_op("rem", 32, 3'd6, 64'hFFFF_FFEC, 64'd3, 5'd7, 34, 64'hFFFF_FFFE);
    run_op("divu", 32, 3'd5, 64'd100, 64'd7, 5'd8, 34, 64'd14);
    run_op("remu", 32, 3'd7, 64'd100, 64'd7, 5'd9, 34, 64'd2);
    run_op("div0", 32, 3'd4, 64'd5, 64'd0, 5'd10, 1, 64'hFFFF_FFFF);
    run_op("rem0", 32, 3'd6, 64'd5, 64'd0, 5'd11, 1, 64'd5);
    run_op("divovf", 32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, 1, 64'h8000_0000);
    run_op("removf", 32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd0, 1, 64'd0);

    // Flush in the middle of a divide.
    @(negedge clk);
    drive(32, 1'b1, 3'd4, 64'hFFFF_FFEC, 64'd3, 5'd4);
    @(posedge clk);
    #1 drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    seen = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (a_vld) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.ready", 64'(a_ready), 64'd1);
    repeat (40) begin
      @(negedge clk);
      if (a_vld) seen = 1'b1;
    end
    chk("flush.nostrobe", 64'(seen), 64'd0);
    run_op("postflush", 32, 3'd0, 64'd3, 64'd4, 5'd3, 2, 64'd12);

    // Flush together with a request in IDLE: nothing is accepted.
    @(negedge clk);
    flush = 1'b1;
    drive(32, 1'b1, 3'd0, 64'd9, 64'd9, 5'd2);
    #1 chk("fidle.stall", 64'(a_stall), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_vld || !a_ready) seen = 1'b1;
    end
    chk("fidle.noaccept", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a divide; rd_data_o still holds 12 from above.
    @(negedge clk);
    drive(32, 1'b1, 3'd5, 64'd1000, 64'd3, 5'd17);
    @(posedge clk);
    #1 drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("arst.outs", {a_data, 27'b0, a_rdo, a_vld, a_wr, a_ready},
           {32'b0, 27'b0, 5'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a_vld) seen = 1'b1;
    end
    chk("arst.nostrobe", 64'(seen), 64'd0);

    run_op("mul64", 64, 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 4, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("mulhu64", 64, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 4,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op("div64", 64, 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd3, 66, 64'hFFFF_FFFF_FFFF_FFFA);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = pick(32);
      y  = pick(32);
      run_ref($sformatf("rnd32_%0d_op%0d", i, op), 32, op, x, y, 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = pick(64);
      y  = pick(64);
      run_ref($sformatf("rnd64_%0d_op%0d", i, op), 64, op, x, y, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle execute unit for RV32M/RV64M multiply and divide. It sits beside the single-cycle ALU in the EX stage. It accepts one operation at a time and holds the pipeline through stall_o until the result is ready. It then presents rd_addr/rd_write/rd_data to EX/MEM for exactly one cycle. Unlike the combinational ALU, it is sequential: the multiplier is pipelined and the divider is iterative. Flush and stall handling are built in.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiplier pipeline depth; valid_o follows accept by exactly MUL_STAGES cycles; legal range 1..4
REG_ADDR_W, 5, destination register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  branch mispredict; aborts any in-flight op
valid_i  in  1  request; sampled only when ready_o=1
op_i  in  3  M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  in  XLEN  dividend / multiplicand
rs2_data  in  XLEN  divisor / multiplier
rd_addr_i  in  REG_ADDR_W  destination register
ready_o  out  1  high only in IDLE
stall_o  out  1  freeze IF/ID/EX
valid_o  out  1  one-cycle result strobe
rd_addr_o  out  REG_ADDR_W  destination, valid with valid_o
rd_write_o  out  1  equals valid_o
rd_data_o  out  XLEN  result, valid with valid_o

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registered outputs (valid_o, rd_write_o, rd_addr_o, rd_data_o) are 0.
  - Reset mid-op drops the op silently.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- Accept: valid_i & ready_o & !flush at a rising edge latches op_i, operands and rd_addr_i. Call that edge cycle 0.
- Multiply path:
  - IDLE->MUL; MUL_STAGES-1 internal register stages, then DONE.
  - valid_o is high in cycle MUL_STAGES.
  - Product is full 2*XLEN bits. Operand signedness: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns bits [XLEN-1:0]; the MULH variants return [2*XLEN-1:XLEN].
- Divide path:
  - DIV_PREP takes absolute values for signed ops and records quotient/remainder signs.
  - DIV_ITER runs XLEN cycles of radix-2 restoring division, one quotient bit per cycle, using a counter of width clog2(XLEN)+1.
  - DIV_FIX applies the signs: quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1).
  - Then DONE. valid_o is high in cycle XLEN+2 (cycle 34 for XLEN=32).
- Divide special cases are resolved in DIV_PREP, skip DIV_ITER, and go to DONE, so valid_o is high in cycle 1:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV gives most-negative; REM gives 0.
- DONE lasts one cycle: valid_o=rd_write_o=1, then back to IDLE. There is no downstream backpressure; EX/MEM always captures the result.
- stall_o (combinational) = (IDLE & valid_i & !flush) | (state ∉ {IDLE, DONE}).
  - stall_o is low in the DONE cycle, so the pipeline advances with the result.
- flush:
  - Any state except DONE returns to IDLE on the next edge; valid_o is never raised for the aborted op.
  - Flush during DONE does not suppress the strobe; the result is already committed as older than the branch.
  - Flush with valid_i in IDLE means no accept.
- rd_addr_i = 0 is still executed; rd_write_o is asserted and the register file discards the write.
- Back-to-back ops: a new accept is possible in the cycle after DONE, the earliest point at which ready_o=1.

Decomposition:
- Shared constants in config.v:
  - funct3 codes OpMul..OpRemu.
  - CatagoryMulDiv.
  - FSM state encodings for this unit.
- Sub-module ex_div_iter: a restoring divider core taking the unsigned operands, with start/done. It holds the remainder/quotient shift registers and the iteration counter.
- Multiplier pipeline and sign handling stay in the top module.

Test Plan:
- MUL 7 × -3 (0xFFFFFFFD), rd=5 -> valid_o at cycle 2, rd_data 0xFFFFFFEB, rd_addr_o 5; stall_o high in cycles 0-1, low in cycle 2.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -20/3 and REM -20/3 -> 0xFFFFFFFA and 0xFFFFFFFE, with valid_o at cycle 34; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF at cycle 1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- flush at cycle 10 of a DIV -> no valid_o, ready_o high at cycle 11; a following MUL 3×4 returns 12 with correct latency.
- rst_n low at cycle 5 of a DIV -> outputs 0 immediately, no strobe; with MUL_STAGES=4 and XLEN=64, the MUL latency is 4 and a DIV strobes at cycle 66.
